// File: rtl/core_pkg.sv
// Shared core definitions: writeback source encoding and default datapath widths.
package core_pkg;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10,
    RES_IMM  = 2'b11
  } result_src_e;

  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned REG_AW_DEF = 5;

endpackage

// File: rtl/load_data_hold.sv
// Keeps synchronous-RAM read data stable while its consumer stage is stalled.
// Output is the live RAM data in the first cycle, the captured copy afterwards.
module load_data_hold
  import core_pkg::*;
#(
  parameter int unsigned W = XLEN_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clear,
  input  logic         i_stall,
  input  logic [W-1:0] i_rd_data,
  output logic [W-1:0] o_rd_data
);

  logic         r_fresh;
  logic [W-1:0] r_hold;

  // RAM data is only valid in the first stage cycle, so capture it on the first stalled edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fresh <= 1'b0;
      r_hold  <= '0;
    end else if (i_clear) begin
      r_fresh <= 1'b0;
    end else if (i_stall) begin
      if (r_fresh) begin
        r_hold  <= i_rd_data;
        r_fresh <= 1'b0;
      end
    end else begin
      r_fresh <= 1'b1;
    end
  end

  assign o_rd_data = r_fresh ? i_rd_data : r_hold;

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline register with stall/flush, load-data hold, x0 filter and result mux.
// Optional perf counters when MEM_WB_PERF_EN is defined.
module mem_wb_pipe_reg
  import core_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_stall,
  input  logic              wb_clear,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic [1:0]        mem_result_src,
  input  logic [XLEN-1:0]   mem_alu_result,
  input  logic [XLEN-1:0]   mem_pc_plus_4,
  input  logic [XLEN-1:0]   mem_imm_ext,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_read_result,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [REG_AW-1:0] wb_rd,
  output logic [XLEN-1:0]   wb_result,
  output logic [XLEN-1:0]   wb_read_result
`ifdef MEM_WB_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_retired,
  output logic [CNT_W-1:0]  perf_bubbles,
  output logic [CNT_W-1:0]  perf_stalls
`endif
);

  logic              r_valid;
  logic              r_reg_write;
  result_src_e       r_result_src;
  logic [REG_AW-1:0] r_rd;
  logic [XLEN-1:0]   r_alu;
  logic [XLEN-1:0]   r_pc4;
  logic [XLEN-1:0]   r_imm;
  logic [XLEN-1:0]   w_read_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_result_src <= RES_ALU;
      r_rd         <= '0;
      r_alu        <= '0;
      r_pc4        <= '0;
      r_imm        <= '0;
    end else if (wb_clear) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_result_src <= RES_ALU;
      r_rd         <= '0;
      r_alu        <= '0;
      r_pc4        <= '0;
      r_imm        <= '0;
    end else if (!wb_stall) begin
      r_valid      <= mem_valid;
      r_reg_write  <= mem_reg_write;
      r_result_src <= result_src_e'(mem_result_src);
      r_rd         <= mem_rd;
      r_alu        <= mem_alu_result;
      r_pc4        <= mem_pc_plus_4;
      r_imm        <= mem_imm_ext;
    end
  end

  load_data_hold #(
    .W (XLEN)
  ) u_load_hold (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (wb_clear),
    .i_stall   (wb_stall),
    .i_rd_data (mem_read_result),
    .o_rd_data (w_read_result)
  );

  assign wb_valid       = r_valid;
  assign wb_rd          = r_rd;
  assign wb_read_result = w_read_result;
  // x0 is hardwired zero; never let a write to it reach the regfile.
  assign wb_reg_write   = r_valid & r_reg_write & (r_rd != '0);

  always_comb begin
    wb_result = r_alu;
    unique case (r_result_src)
      RES_ALU:  wb_result = r_alu;
      RES_LOAD: wb_result = w_read_result;
      RES_PC4:  wb_result = r_pc4;
      RES_IMM:  wb_result = r_imm;
      default:  wb_result = r_alu;
    endcase
  end

`ifdef MEM_WB_PERF_EN
  logic [CNT_W-1:0] r_retired;
  logic [CNT_W-1:0] r_bubbles;
  logic [CNT_W-1:0] r_stalls;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retired <= '0;
      r_bubbles <= '0;
      r_stalls  <= '0;
    end else if (wb_stall) begin
      r_stalls <= r_stalls + 1'b1;
    end else if (r_valid) begin
      r_retired <= r_retired + 1'b1;
    end else begin
      r_bubbles <= r_bubbles + 1'b1;
    end
  end

  assign perf_retired = r_retired;
  assign perf_bubbles = r_bubbles;
  assign perf_stalls  = r_stalls;
`else
  if (CNT_W == 0) begin : g_bad_cnt_w
    $error("CNT_W must be nonzero");
  end
`endif

endmodule
